board_ctrl: RTL and testbench

- Game-state engine that consumes the one-hot left/right/put pulses from the input stage (`lrp_self`, `lrp_opponent`).
- Owns the Connect-4 board, column heights, cursor, turn alternation, win/draw detection and restart.
- Sits directly downstream of the input stage; its board bitmaps and cursor feed the display/renderer.

---
 rtl/board_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_board_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/board_ctrl.sv
// -----------------------------------------------------------------------------
// board_ctrl -- Connect-4 game-state engine.
//
// Owns the board bitmaps, the column heights, the cursor, turn alternation,
// win/draw detection and restart. It consumes one-hot {left,right,put}
// actions from the local buttons and from the opponent link.
//
// Ports:
//   clk           system clock
//   rst           asynchronous, active-low reset
//   lrp_self      {left,right,put} one-cycle pulses from local buttons
//   lrp_opponent  {left,right,put} from the opponent link, may be held
//   my_first      static strap, 1 = local player moves first
//   cursor_col    column selected by the player whose turn it is
//   self_turn     1 = local player's move
//   self_map      local pieces, bit row*COLS+col, row 0 = bottom
//   opp_map       opponent pieces, same indexing
//   busy          high while a move is being placed/checked/handed over
//   game_over     high once the game has ended
//   winner        00 none, 01 self, 10 opponent, 11 draw
//
// Build option:
//   CURSOR_WRAP_EN  when defined, left/right wrap around the board edges
//                   instead of saturating.
// -----------------------------------------------------------------------------
module board_ctrl #(
  parameter int COLS = 7,
  parameter int ROWS = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              lrp_self,
  input  logic [2:0]              lrp_opponent,
  input  logic                    my_first,
  output logic [$clog2(COLS)-1:0] cursor_col,
  output logic                    self_turn,
  output logic [ROWS*COLS-1:0]    self_map,
  output logic [ROWS*COLS-1:0]    opp_map,
  output logic                    busy,
  output logic                    game_over,
  output logic [1:0]              winner
);
  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int HW    = $clog2(ROWS + 1);
  localparam int CELLS = ROWS * COLS;
  localparam int MW    = $clog2(CELLS + 1);
  localparam logic [CW-1:0] CUR_MID = CW'(COLS / 2);
  localparam logic [CW-1:0] CUR_MAX = CW'(COLS - 1);

  typedef enum logic [2:0] {S_PLAY, S_DROP, S_CHECK, S_SWITCH, S_OVER} state_t;
  state_t r_state, w_state_next;

  logic [CELLS-1:0] r_self_map, r_opp_map;
  logic [HW-1:0]    r_height [COLS];
  logic [MW-1:0]    r_moves;
  logic [CW-1:0]    r_cursor;
  logic             r_turn_swap;   // self_turn is my_first XOR this flag
  logic [2:0]       r_opp_prev;
  logic [RW-1:0]    r_row;
  logic [CW-1:0]    r_col;
  logic [1:0]       r_dir;
  logic             r_win;
  logic [1:0]       r_winner;

  logic             w_self_turn;
  logic [2:0]       w_opp_edge, w_act;
  logic             w_left, w_right, w_put, w_restart, w_col_full, w_board_full;
  logic [HW-1:0]    w_cur_height;
  logic [CELLS-1:0] w_drop_bit, w_mine;
  logic [2:0]       w_count;
  logic             w_win_now;

  assign w_self_turn  = my_first ^ r_turn_swap;
  // The link may hold a code for several cycles; only a rising bit acts.
  assign w_opp_edge   = lrp_opponent & ~r_opp_prev;
  assign w_act        = w_self_turn ? lrp_self : w_opp_edge;
  assign w_left       = w_act[2];
  assign w_right      = ~w_act[2] & w_act[1];
  assign w_put        = ~w_act[2] & ~w_act[1] & w_act[0];
  // A finished game can be restarted by either player.
  assign w_restart    = lrp_self[0] | w_opp_edge[0];
  assign w_cur_height = r_height[r_cursor];
  assign w_col_full   = (w_cur_height == HW'(ROWS));
  assign w_board_full = (r_moves == MW'(CELLS));
  assign w_drop_bit   = CELLS'(1) << (int'(w_cur_height) * COLS + int'(r_cursor));
  assign w_mine       = w_self_turn ? r_self_map : r_opp_map;

  // Run length of the mover's pieces on both sides of the placed cell along
  // the direction selected by r_dir (up to 3 per side, stops at the edge).
  always_comb begin
    int dr, dc, rr, cc, step;
    logic run;
    w_count = '0;
    dr = 0; dc = 1; rr = 0; cc = 0; step = 0; run = 1'b0;
    case (r_dir)
      2'd0:    begin dr = 0; dc = 1;  end
      2'd1:    begin dr = 1; dc = 0;  end
      2'd2:    begin dr = 1; dc = 1;  end
      default: begin dr = 1; dc = -1; end
    endcase
    for (int s = 0; s < 2; s++) begin
      run = 1'b1;
      for (int k = 1; k <= 3; k++) begin
        step = (s == 0) ? k : -k;
        rr = int'(r_row) + step * dr;
        cc = int'(r_col) + step * dc;
        if (run && rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS && w_mine[rr*COLS+cc])
          w_count = w_count + 3'd1;
        else
          run = 1'b0;
      end
    end
  end
  assign w_win_now = (w_count >= 3'd3);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_PLAY;
    else      r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_PLAY:   if (w_put && !w_col_full) w_state_next = S_DROP;
      S_DROP:   w_state_next = S_CHECK;
      S_CHECK:  if (r_dir == 2'd3)
                  w_state_next = (r_win || w_win_now || w_board_full) ? S_OVER : S_SWITCH;
      S_SWITCH: w_state_next = S_PLAY;
      S_OVER:   if (w_restart) w_state_next = S_PLAY;
      default:  w_state_next = S_PLAY;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = 1'b0;
    game_over = 1'b0;
    case (r_state)
      S_DROP, S_CHECK, S_SWITCH: busy = 1'b1;
      S_OVER:                    game_over = 1'b1;
      default: ;
    endcase
  end

  assign cursor_col = r_cursor;
  assign self_turn  = w_self_turn;
  assign self_map   = r_self_map;
  assign opp_map    = r_opp_map;
  assign winner     = r_winner;

  // Board, cursor and move bookkeeping
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_self_map  <= '0;
      r_opp_map   <= '0;
      for (int i = 0; i < COLS; i++) r_height[i] <= '0;
      r_moves     <= '0;
      r_cursor    <= CUR_MID;
      r_turn_swap <= 1'b0;
      r_opp_prev  <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_dir       <= '0;
      r_win       <= 1'b0;
      r_winner    <= 2'b00;
    end else begin
      r_opp_prev <= lrp_opponent;
      case (r_state)
        S_PLAY: begin
          if (w_left) begin
            if (r_cursor == '0) begin
`ifdef CURSOR_WRAP_EN
              r_cursor <= CUR_MAX;
`else
              r_cursor <= r_cursor;
`endif
            end else begin
              r_cursor <= r_cursor - CW'(1);
            end
          end else if (w_right) begin
            if (r_cursor == CUR_MAX) begin
`ifdef CURSOR_WRAP_EN
              r_cursor <= '0;
`else
              r_cursor <= r_cursor;
`endif
            end else begin
              r_cursor <= r_cursor + CW'(1);
            end
          end
        end
        S_DROP: begin
          if (w_self_turn) r_self_map <= r_self_map | w_drop_bit;
          else             r_opp_map  <= r_opp_map | w_drop_bit;
          r_height[r_cursor] <= w_cur_height + HW'(1);
          r_moves <= r_moves + MW'(1);
          r_row   <= RW'(w_cur_height);
          r_col   <= r_cursor;
          r_dir   <= '0;
          r_win   <= 1'b0;
        end
        S_CHECK: begin
          r_dir <= r_dir + 2'd1;
          if (w_win_now) r_win <= 1'b1;
          if (r_dir == 2'd3) begin
            if (r_win || w_win_now) r_winner <= w_self_turn ? 2'b01 : 2'b10;
            else if (w_board_full)  r_winner <= 2'b11;
          end
        end
        S_SWITCH: begin
          r_turn_swap <= ~r_turn_swap;
          r_cursor    <= CUR_MID;
        end
        S_OVER: begin
          if (w_restart) begin
            r_self_map  <= '0;
            r_opp_map   <= '0;
            for (int i = 0; i < COLS; i++) r_height[i] <= '0;
            r_moves     <= '0;
            r_cursor    <= CUR_MID;
            r_turn_swap <= 1'b0;
            r_win       <= 1'b0;
            r_winner    <= 2'b00;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_board_ctrl.sv
// -----------------------------------------------------------------------------
// tb_board_ctrl -- self-checking bench for board_ctrl.
// A game model (2-D board array, full-board four-in-a-row scan) predicts the
// outputs after each action; directed sequences are followed by random play.
// -----------------------------------------------------------------------------
module tb_board_ctrl;
  localparam int COLS  = 7;
  localparam int ROWS  = 6;
  localparam int CELLS = ROWS * COLS;
  localparam logic [2:0] A_L = 3'b100;
  localparam logic [2:0] A_R = 3'b010;
  localparam logic [2:0] A_P = 3'b001;
`ifdef CURSOR_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [2:0]       lrp_self = '0;
  logic [2:0]       lrp_opponent = '0;
  logic             my_first = 1'b1;
  logic [2:0]       cursor_col;
  logic             self_turn;
  logic [CELLS-1:0] self_map, opp_map;
  logic             busy, game_over;
  logic [1:0]       winner;

  board_ctrl #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .rst(rst), .lrp_self(lrp_self), .lrp_opponent(lrp_opponent),
    .my_first(my_first), .cursor_col(cursor_col), .self_turn(self_turn),
    .self_map(self_map), .opp_map(opp_map), .busy(busy),
    .game_over(game_over), .winner(winner)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_txn = 0;

  // Game model: 0 empty, 1 self, 2 opponent
  int         m_board [ROWS][COLS];
  int         m_h [COLS];
  int         m_moves, m_cur;
  bit         m_turn, m_over;
  logic [1:0] m_winner;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) m_board[r][c] = 0;
    for (int c = 0; c < COLS; c++) m_h[c] = 0;
    m_moves = 0; m_cur = COLS / 2; m_turn = my_first; m_over = 0; m_winner = 2'b00;
  endtask

  function automatic bit four_in_row(int who);
    int dr [4];
    int dc [4];
    int rr, cc;
    bit ok;
    dr = '{0, 1, 1, 1};
    dc = '{1, 0, 1, -1};
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        for (int d = 0; d < 4; d++) begin
          ok = 1'b1;
          for (int k = 0; k < 4; k++) begin
            rr = r + k * dr[d];
            cc = c + k * dc[d];
            if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) ok = 1'b0;
            else if (m_board[rr][cc] != who) ok = 1'b0;
          end
          if (ok) return 1'b1;
        end
    return 1'b0;
  endfunction

  function automatic logic [63:0] map_of(int who);
    logic [63:0] m;
    m = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (m_board[r][c] == who) m[r*COLS+c] = 1'b1;
    return m;
  endfunction

  task automatic model_apply(input bit from_opp, input logic [2:0] code, output bit dropped);
    int who;
    dropped = 1'b0;
    if (m_over) begin
      if (code == A_P) model_reset();
      return;
    end
    if (from_opp == m_turn) return;          // inactive source
    case (code)
      A_L: if (m_cur > 0) m_cur--; else if (WRAP) m_cur = COLS - 1;
      A_R: if (m_cur < COLS - 1) m_cur++; else if (WRAP) m_cur = 0;
      A_P: if (m_h[m_cur] < ROWS) begin
        who = m_turn ? 1 : 2;
        m_board[m_h[m_cur]][m_cur] = who;
        m_h[m_cur]++;
        m_moves++;
        dropped = 1'b1;
        if (four_in_row(who)) begin
          m_over = 1'b1; m_winner = m_turn ? 2'b01 : 2'b10;
        end else if (m_moves == CELLS) begin
          m_over = 1'b1; m_winner = 2'b11;
        end else begin
          m_turn = !m_turn; m_cur = COLS / 2;
        end
      end
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    check({tag, ".cursor"}, cursor_col, m_cur);
    check({tag, ".turn"},   self_turn,  m_turn);
    check({tag, ".smap"},   self_map,   map_of(1));
    check({tag, ".omap"},   opp_map,    map_of(2));
    check({tag, ".busy"},   busy,       0);
    check({tag, ".over"},   game_over,  m_over);
    check({tag, ".winner"}, winner,     m_winner);
  endtask

  // One action: idle cycle, one-cycle action, and the full move sequence if
  // a piece was dropped (with junk on both inputs while the engine is busy).
  task automatic act(input bit from_opp, input logic [2:0] code);
    bit dropped;
    int busy_cnt;
    string nm;
    lrp_self = '0; lrp_opponent = '0;
    @(negedge clk);
    if (from_opp) lrp_opponent = code; else lrp_self = code;
    @(negedge clk);
    lrp_self = '0; lrp_opponent = '0;
    model_apply(from_opp, code, dropped);
    if (dropped) begin
      busy_cnt = 0;
      for (int k = 0; k < 5; k++) begin
        if (busy) busy_cnt++;
        if (k < 4) begin
          lrp_self     = 3'b001 << $urandom_range(0, 2);
          lrp_opponent = 3'($urandom_range(0, 7));
        end else begin
          lrp_self = '0; lrp_opponent = '0;
        end
        @(negedge clk);
      end
      check("busy_len", busy_cnt, 5);
      check("over_at5", game_over, m_over);
      check("busy_at5", busy, !m_over);
      @(negedge clk);
    end
    n_txn++;
    case (code)
      A_L: nm = "left"; A_R: nm = "right"; default: nm = "put";
    endcase
    $display("txn %0d: %s %s drop=%0d -> cur=%0d turn=%0d over=%0d winner=%0d",
             n_txn, from_opp ? "opp" : "self", nm, dropped, cursor_col, self_turn,
             game_over, winner);
    check_all("txn");
  endtask

  task automatic play_col(input bit from_opp, input int col);
    for (int g = 0; g < COLS && m_cur > col; g++) act(from_opp, A_L);
    for (int g = 0; g < COLS && m_cur < col; g++) act(from_opp, A_R);
    act(from_opp, A_P);
  endtask

  task automatic do_reset(input bit first);
    @(negedge clk);
    rst = 1'b0; lrp_self = '0; lrp_opponent = '0; my_first = first;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bit d;
    int seq_opp [11];
    int seq_col [11];

    // Reset values
    do_reset(1'b1);
    check("rst_cursor", cursor_col, 3);
    check("rst_turn", self_turn, 1);
    check("rst_winner", winner, 0);

    // Left x5 from the centre
    repeat (5) act(1'b0, A_L);
    check("left5", cursor_col, WRAP ? 5 : 0);

    // Vertical win in column 0
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) begin
      play_col(1'b0, 0);
      if (i < 3) play_col(1'b1, 1);
    end
    check("col0_map", self_map, 64'h204081);
    check("col0_winner", winner, 2'b01);
    check("col0_over", game_over, 1);
    act(1'b0, A_L);
    act(1'b1, A_L);
    act(1'b0, A_R);
    check("over_frozen", self_map, 64'h204081);
    act(1'b0, A_P);
    check("restart_turn", self_turn, 1);
    check("restart_map", self_map, 0);

    // Fill column 3, then one more put
    for (int i = 0; i < 6; i++) act(i % 2 == 1, A_P);
    act(1'b0, A_P);
    check("full_turn", self_turn, 1);
    check("full_busy", busy, 0);

    // Opponent held input on the wrong turn, then on its own turn
    do_reset(1'b1);
    @(negedge clk);
    lrp_opponent = A_P;
    repeat (10) @(negedge clk);
    lrp_opponent = '0;
    @(negedge clk);
    check_all("opp_wrong_turn");
    act(1'b0, A_P);
    lrp_opponent = A_P;
    model_apply(1'b1, A_P, d);
    repeat (20) @(negedge clk);
    lrp_opponent = '0;
    @(negedge clk);
    check_all("opp_held");
    check("opp_held_pieces", $countones(opp_map), 1);

    // Reset while checking
    do_reset(1'b1);
    lrp_self = A_P;
    @(negedge clk);
    lrp_self = '0;
    @(negedge clk);
    check("midcheck_busy", busy, 1);
    #5 rst = 1'b0;
    #1 model_reset();
    check_all("midcheck_rst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Up-right diagonal (0,0)..(3,3) for self
    do_reset(1'b1);
    seq_opp = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    seq_col = '{0, 1, 1, 2, 3, 2, 2, 3, 6, 3, 3};
    for (int i = 0; i < 11; i++) play_col(seq_opp[i] != 0, seq_col[i]);
    check("diag_winner", winner, 2'b01);
    check("diag_over", game_over, 1);

    // Random play, opponent first then self first
    for (int pass = 0; pass < 2; pass++) begin
      do_reset(pass == 1);
      for (int t = 0; t < 120; t++) begin
        int r;
        bit src;
        r   = $urandom_range(0, 3);
        src = ($urandom_range(0, 9) < 8) ? !m_turn : m_turn;
        act(src, (r == 0) ? A_L : (r == 1) ? A_R : A_P);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
